// File: rtl/io_sched_pkg.sv
// io_sched_pkg: shared constants and state encoding for the IO lane scheduler.
package io_sched_pkg;
    localparam int LANES     = 4;
    localparam int LANE_W    = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = $clog2(MAX_WORDS);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/io_lane_tracker.sv
// io_lane_tracker: per-lane start level and finish flag.
module io_lane_tracker (
    input  logic clk,
    input  logic reset_n,
    input  logic arm_i,
    input  logic done_i,
    input  logic clear_i,
    output logic start_o,
    output logic finish_o
);
    logic start_q, finish_q;
    assign start_o  = start_q;
    assign finish_o = finish_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            start_q  <= arm_i ? 1'b1 : (done_i ? 1'b0 : start_q);
            finish_q <= clear_i ? 1'b0 : ((start_q && done_i) ? 1'b1 : finish_q);
        end
    end
endmodule

// File: rtl/io_lane_scheduler.sv
// io_lane_scheduler: steers bus words into four lane buffers, runs loaded lanes, reports completion/overflow.
module io_lane_scheduler
    import io_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    int_req,
    input  logic                    process,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*LANE_W-1:0] data_in,
    input  logic                    data_valid,
    input  logic                    eob,
    output logic                    next,
    output logic [LANES*LANE_W-1:0] lane_data,
    output logic [LANES-1:0]        lane_load,
    output logic [LANES-1:0]        start,
    input  logic [LANES-1:0]        done,
    output logic                    busy,
    output logic                    complete,
    output logic                    err
);
    state_t                  state_q;
    logic [LANES-1:0]        load_mask_q, loaded_mask_q, lane_load_q;
    logic [CNT_W-1:0]        word_cnt_q;
    logic [LANES*LANE_W-1:0] lane_data_q;
    logic                    complete_q, err_q;
    logic [LANES-1:0]        finish, arm, fin_d;
    logic                    run_req;

    assign next      = state_q == LOAD;
    assign busy      = state_q != IDLE;
    assign lane_data = lane_data_q;
    assign lane_load = lane_load_q;
    assign complete  = complete_q;
    assign err       = err_q;
    assign run_req   = state_q == IDLE && int_req && process;
    assign arm       = run_req ? loaded_mask_q : '0;
    // finish as it will be after this edge, so DONE follows the last done by one cycle
    assign fin_d     = finish | (start & done);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        io_lane_tracker u_trk (
            .clk     (clk),
            .reset_n (reset_n),
            .arm_i   (arm[l]),
            .done_i  (done[l]),
            .clear_i (state_q == DONE),
            .start_o (start[l]),
            .finish_o(finish[l])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            load_mask_q   <= '0;
            loaded_mask_q <= '0;
            lane_load_q   <= '0;
            word_cnt_q    <= '0;
            lane_data_q   <= '0;
            complete_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            lane_load_q <= '0;
            complete_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (int_req && process) begin
                        state_q    <= (loaded_mask_q == '0) ? DONE : RUN;
                        complete_q <= loaded_mask_q == '0;
                    end else if (int_req && lane_en != '0) begin
                        load_mask_q <= lane_en;
                        err_q       <= 1'b0;
                        word_cnt_q  <= '0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (data_valid) begin
                        for (int i = 0; i < LANES; i++)
                            if (load_mask_q[i])
                                lane_data_q[i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
                        lane_load_q   <= load_mask_q;
                        loaded_mask_q <= loaded_mask_q | load_mask_q;
                        word_cnt_q    <= word_cnt_q + 1'b1;
                        // counter at its top value without eob is the overflow condition
                        if (eob || word_cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                            state_q <= IDLE;
                            err_q   <= !eob;
                        end
                    end
                end
                RUN: begin
                    if (fin_d == loaded_mask_q) begin
                        state_q    <= DONE;
                        complete_q <= 1'b1;
                    end
                end
                DONE: begin
                    loaded_mask_q <= '0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
